dsp_xor_descrambler: RTL

//  Receive-side descrambler for streams scrambled by XOR with an LFSR keystream.

---
 rtl/dsp_xor_descrambler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dsp_xor_descrambler.sv
// ----------------------------------------------------------------------------
// dsp_xor_descrambler
//
// Receive-side descrambler. Each accepted beat is XORed with the current state
// of a 48-bit Fibonacci LFSR keystream. The XOR is done in a DSP48E2 slice in
// ALU XOR mode (ALUMODE=4'b0100, OPMODE=9'b000110011: X=A:B, Z=C, no multiplier).
// The slice is described behaviourally here. Its register set is A/B/C (1 stage)
// and P (1 stage), with per-register CE and synchronous RST.
//
// Parameters
//   width  data width, 1..48
//   POLY   LFSR tap mask (default x^48+x^47+x^21+x^20+1)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous reset, active-low
//   seed_load  in   load keystream seed (pulse), has priority over in_valid
//   seed       in   48-bit seed (zero is replaced by 48'h1)
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid && in_ready
//   in_data    in   scrambled data
//   out_valid  out  output beat valid
//   out_ready  in   consumer ready
//   out_data   out  descrambled data (zero when out_valid is low)
//   beat_count out  completed output beats (only with DSP_XOR_DESCRAMBLER_STATS_EN)
//
// Optional feature macro: DSP_XOR_DESCRAMBLER_STATS_EN
// ----------------------------------------------------------------------------
module dsp_xor_descrambler #(
    parameter int          width = 48,
    parameter logic [47:0] POLY  = 48'hC00000180000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [47:0]       seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [width-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef DSP_XOR_DESCRAMBLER_STATS_EN
    output logic [width-1:0]  out_data,
    output logic [31:0]       beat_count
`else
    output logic [width-1:0]  out_data
`endif
);

    generate
        if ((width < 1) || (width > 48)) begin : g_width_check
            $error("dsp_xor_descrambler: width must be in 1..48");
        end
    endgenerate

    localparam logic [0:0] UNSEEDED = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    // One Fibonacci LFSR step: shift left, feed back the parity of the tapped bits.
    function automatic logic [47:0] lfsr_step(input logic [47:0] k);
        return {k[46:0], ^(k & POLY)};
    endfunction

    logic [0:0]  state_r;
    logic [47:0] k_r;
    logic        v1_r;
    logic        v2_r;

    // DSP48E2 internal registers
    logic [29:0] dsp_a_r;
    logic [17:0] dsp_b_r;
    logic [47:0] dsp_c_r;
    logic [47:0] dsp_p_r;

    logic        ce_s;
    logic        in_ready_s;
    logic        accept_s;
    logic [47:0] c_ext_s;

    // Stall control, input handshake and operand zero-extension
    always_comb begin
        ce_s = (!v2_r) || out_ready;
        case (state_r)
            UNSEEDED: in_ready_s = 1'b0;
            RUN:      in_ready_s = ce_s && !seed_load;
            default:  in_ready_s = 1'b0;
        endcase
        accept_s = in_valid && in_ready_s;
        c_ext_s = 48'd0;
        c_ext_s[width-1:0] = in_data;
    end

    // FSM and keystream; a seed load overrides any keystream advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= UNSEEDED;
            k_r     <= 48'h1;
        end else begin
            if (seed_load) begin
                state_r <= RUN;
                k_r     <= (seed == 48'd0) ? 48'h1 : seed;
            end else if (accept_s) begin
                k_r <= lfsr_step(k_r);
            end
        end
    end

    // Valid pipeline tracking the A/B/C -> P stages; frozen while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
        end else if (ce_s) begin
            v1_r <= accept_s;
            v2_r <= v1_r;
        end
    end

    // DSP slice registers: synchronous RST from ~reset, CE from stall control.
    // Stale contents after reset are harmless because v1/v2 mask them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dsp_a_r <= 30'd0;
            dsp_b_r <= 18'd0;
            dsp_c_r <= 48'd0;
            dsp_p_r <= 48'd0;
        end else if (ce_s) begin
            dsp_a_r <= k_r[47:18];
            dsp_b_r <= k_r[17:0];
            dsp_c_r <= c_ext_s;
            dsp_p_r <= {dsp_a_r, dsp_b_r} ^ dsp_c_r;
        end
    end

    // Output presentation; data forced to zero when no beat is held
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = v2_r;
        if (v2_r) begin
            out_data = dsp_p_r[width-1:0];
        end else begin
            out_data = '0;
        end
    end

`ifdef DSP_XOR_DESCRAMBLER_STATS_EN
    logic [31:0] beat_count_r;

    // Completed-beat counter; seed_load clear wins over a same-cycle beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_count_r <= 32'd0;
        end else if (seed_load) begin
            beat_count_r <= 32'd0;
        end else if (v2_r && out_ready) begin
            beat_count_r <= beat_count_r + 32'd1;
        end
    end

    assign beat_count = beat_count_r;
`endif

endmodule
